// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and default width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_adder_pkg;

    localparam int DEF_WIDTH = 8;

    // 2'd3 is never entered by design; the controller falls back to IDLE if it is.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder stage used by the serial adder, one bit per clock.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module full_adder (
    input  logic in1,
    input  logic in2,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic half;

    // Sum and carry of one bit position
    always_comb begin
        half = in1 ^ in2;
        sum  = half ^ cin;
        cout = (in1 & in2) | (cin & half);
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: latches a, b, cin on start and adds LSB first through one full_adder.
// Latency: done pulses WIDTH cycles after start is accepted; one add per WIDTH+2 cycles at most.
// Backpressure: start is only sampled in IDLE; requests while busy or done are dropped, not queued.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 finished bits; the last bit comes straight from the adder.
    logic [WIDTH-2:0] sum_sr;
    logic [WIDTH-1:0] sum_nxt;
    logic             c_reg;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;

    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .in1  (a_sr[0]),
        .in2  (b_sr[0]),
        .cin  (c_reg),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign sum_nxt  = {fa_sum, sum_sr};

    // Outputs decode directly from the state register, so nothing combinational reaches them from inputs
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

    // State register
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)    state_d = ST_RUN;
            ST_RUN:  if (last_bit) state_d = ST_DONE;
            ST_DONE:               state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // Operand capture, serial shifting, carry chain and result registers
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            c_reg  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        c_reg <= cin;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_nxt[WIDTH-1:1];
                    c_reg  <= fa_cout;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        sum  <= sum_nxt;
                        cout <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH:0] res;
        int             acc;
    } exp_t;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    exp_t           sb[$];
    int             errors   = 0;
    int             checks   = 0;
    int             edge_cnt = 0;
    int             done_cnt = 0;
    logic [WIDTH:0] hold     = '0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) edge_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: pops the scoreboard on each done pulse, otherwise the result must hold
    always @(negedge sys_clk) begin
        exp_t e;
        if (!sys_rst_n) begin
            hold = '0;
        end else if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result", 32'({cout, sum}), 32'(e.res));
                chk("latency", 32'(edge_cnt - e.acc), 32'(WIDTH));
            end
            hold = {cout, sum};
        end else begin
            chk("result_hold", 32'({cout, sum}), 32'(hold));
        end
    end

    // Called at posedge+1; waits for IDLE, presents one start, then scrambles the operand inputs
    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic ic, input logic [WIDTH:0] exp_res);
        int   n;
        exp_t e;
        n = 0;
        while ((busy || done) && n < 100) begin
            @(posedge sys_clk); #1;
            n++;
        end
        if (n >= 100) chk("idle_timeout", 32'd0, 32'd1);
        start = 1'b1;
        a     = ia;
        b     = ib;
        cin   = ic;
        e.res = exp_res;
        e.acc = edge_cnt + 1;
        sb.push_back(e);
        @(posedge sys_clk); #1;
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        cin   = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy || done) && n < 200) begin
            @(posedge sys_clk); #1;
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int             bc;
        int             base;
        logic [WIDTH-1:0] ra, rb;
        logic             rc;
        logic [WIDTH:0]   rs;

        sys_rst_n = 1'b0;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        // 1: zero operands, busy window length
        issue(8'h00, 8'h00, 1'b0, 9'h000);
        bc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (done) break;
            if (busy) bc++;
        end
        chk("busy_cycles", 32'(bc), 32'd8);
        @(posedge sys_clk); #1;
        drain();

        // 2: full ripple with wrap-around
        issue(8'hFF, 8'h01, 1'b0, 9'h100);
        drain();

        // 3: carry-in ripples through every bit
        issue(8'hA5, 8'h5A, 1'b1, 9'h100);
        drain();

        // 4: start during RUN is ignored, single done pulse
        base = done_cnt;
        issue(8'h12, 8'h34, 1'b0, 9'h046);
        repeat (2) @(posedge sys_clk);
        #1;
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        @(posedge sys_clk); #1;
        start = 1'b0;
        drain();
        repeat (12) @(posedge sys_clk);
        #1;
        chk("single_done", 32'(done_cnt - base), 32'd1);

        // 5: reset mid-RUN clears everything, then a fresh add
        issue(8'h3C, 8'hC3, 1'b0, 9'h0FF);
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        @(posedge sys_clk); #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum",  32'(sum),  32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        sys_rst_n = 1'b1;
        sb.delete();
        @(posedge sys_clk); #1;
        issue(8'h3C, 8'hC3, 1'b0, 9'h0FF);
        drain();

        // 6: random back-to-back adds
        for (int i = 0; i < 1000; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            rs = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
            issue(ra, rb, rc, rs);
        end
        drain();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
